// File: rtl/instr_fetch_unit.sv
// Program store and fetch stage: loads bytes over a valid/ready handshake, then serves mem[PC] on each CLK_ rise.
// Latency: instruction/fetch_strobe update 1 _CLK cycle after CLK_ is first sampled high in RUN.
// Backpressure: load_ready is high in IDLE/LOAD and drops for good in RUN; only RESET reopens loading.
//
// Ports:
//   _CLK, RESET          system clock, synchronous active-high reset
//   CLK_, PC             datapath derived clock (sampled as data) and program counter
//   load_valid/_data/_last, load_ready   byte loader handshake
//   running, prog_len    RUN indicator and number of bytes loaded (0..DEPTH)
//   instruction, fetch_strobe            fetched instruction and its one-cycle update pulse
module instr_fetch_unit #(
  parameter int         DEPTH      = 256,
  parameter logic [7:0] FILL_INSTR = 8'h00
) (
  input  logic       _CLK,
  input  logic       RESET,
  input  logic       CLK_,
  input  logic [7:0] PC,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       running,
  output logic [8:0] prog_len,
  output logic [7:0] instruction,
  output logic       fetch_strobe
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] mem [DEPTH];
  logic       clk_q;
  logic       rise;
  logic       xfer;
  logic       fetch;
  logic [8:0] len_inc;

  assign load_ready = (state != RUN);
  assign running    = (state == RUN);
  assign xfer       = load_valid & load_ready;
  assign len_inc    = prog_len + 9'd1;
  assign rise       = CLK_ & ~clk_q;
  // Rises seen outside RUN (including the edge that enters RUN) are dropped.
  assign fetch      = running & rise;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (load_valid) begin
          // Filling the last slot ends the load even without load_last.
          if (load_last || (len_inc == DEPTH_LEN)) state_nxt = RUN;
          else                                     state_nxt = LOAD;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      state        <= IDLE;
      prog_len     <= 9'd0;
      clk_q        <= 1'b0;
      instruction  <= 8'h00;
      fetch_strobe <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_q        <= CLK_;
      fetch_strobe <= fetch;
      if (xfer) prog_len <= len_inc;
      if (fetch) begin
        // prog_len <= DEPTH, so PC < prog_len also keeps the index in range;
        // PC beyond the program (or beyond DEPTH) never aliases.
        if ({1'b0, PC} < prog_len) instruction <= mem[PC[AW-1:0]];
        else                       instruction <= FILL_INSTR;
      end
    end
  end

  // Program memory is deliberately not cleared by reset.
  always_ff @(posedge _CLK) begin
    if (!RESET && xfer) mem[prog_len[AW-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  // DEPTH=256 instance
  logic       ck, vld, lst, rdy, run, stb;
  logic [7:0] pc, dat, ins;
  logic [8:0] len;
  // DEPTH=4 instance
  logic       ck4, vld4, lst4, rdy4, run4, stb4;
  logic [7:0] pc4, dat4, ins4;
  logic [8:0] len4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(256), .FILL_INSTR(8'h00)) dut (
    ._CLK(clk), .RESET(rst), .CLK_(ck), .PC(pc),
    .load_valid(vld), .load_data(dat), .load_last(lst), .load_ready(rdy),
    .running(run), .prog_len(len), .instruction(ins), .fetch_strobe(stb)
  );

  instr_fetch_unit #(.DEPTH(4), .FILL_INSTR(8'h00)) dut4 (
    ._CLK(clk), .RESET(rst), .CLK_(ck4), .PC(pc4),
    .load_valid(vld4), .load_data(dat4), .load_last(lst4), .load_ready(rdy4),
    .running(run4), .prog_len(len4), .instruction(ins4), .fetch_strobe(stb4)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] exp_ins;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] prog [6];

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int strobes;
    prog[0] = 8'h71; prog[1] = 8'h4D; prog[2] = 8'h74;
    prog[3] = 8'hB7; prog[4] = 8'h05; prog[5] = 8'hC2;
    vecs[0] = '{8'h00, 8'h71};
    vecs[1] = '{8'h01, 8'h4D};
    vecs[2] = '{8'h02, 8'h74};
    vecs[3] = '{8'h03, 8'hB7};
    vecs[4] = '{8'h04, 8'h05};
    vecs[5] = '{8'h05, 8'hC2};
    vecs[6] = '{8'h06, 8'h00};
    vecs[7] = '{8'hFF, 8'h00};
    vecs[8] = '{8'h02, 8'h74};

    rst = 1'b1; ck = 1'b0; vld = 1'b0; lst = 1'b0; pc = 8'h00; dat = 8'h00;
    ck4 = 1'b0; vld4 = 1'b0; lst4 = 1'b0; pc4 = 8'h00; dat4 = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check("rst load_ready", 32'(rdy), 32'd1);
    check("rst running", 32'(run), 32'd0);
    check("rst prog_len", 32'(len), 32'd0);
    check("rst instruction", 32'(ins), 32'h00);
    check("rst fetch_strobe", 32'(stb), 32'd0);

    // Load 6 bytes while CLK_ toggles; the final rise coincides with the last transfer.
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; dat = prog[i]; lst = (i == 5); ck = (i % 2 == 1);
      check("load ready", 32'(rdy), 32'd1);
      tick();
      check("load no strobe", 32'(stb), 32'd0);
      check("load prog_len", 32'(len), 32'(i + 1));
    end
    vld = 1'b0; lst = 1'b0;
    check("run after last", 32'(run), 32'd1);
    check("ready low in run", 32'(rdy), 32'd0);
    check("prog_len 6", 32'(len), 32'd6);
    tick();  // CLK_ still high: the rise at the RUN-entry edge was discarded
    check("entry rise dropped strobe", 32'(stb), 32'd0);
    check("entry rise dropped instr", 32'(ins), 32'h00);
    ck = 1'b0;
    tick();

    // Fetch table: CLK_ high 2 cycles, low 2 cycles; stray load_valid in RUN.
    for (int i = 0; i < 9; i++) begin
      pc = vecs[i].pc; ck = 1'b1; vld = 1'b1; dat = 8'hAA;
      tick();
      check($sformatf("fetch[%0d] instr", i), 32'(ins), 32'(vecs[i].exp_ins));
      check($sformatf("fetch[%0d] strobe", i), 32'(stb), 32'd1);
      pc = ~vecs[i].pc;
      tick();
      check($sformatf("fetch[%0d] strobe once", i), 32'(stb), 32'd0);
      ck = 1'b0;
      tick();
      check($sformatf("fetch[%0d] hold", i), 32'(ins), 32'(vecs[i].exp_ins));
      check($sformatf("fetch[%0d] low no strobe", i), 32'(stb), 32'd0);
      tick();
    end
    vld = 1'b0;
    check("run ignores load", 32'(len), 32'd6);

    // CLK_ held high for 10 cycles gives exactly one fetch.
    pc = 8'h03; ck = 1'b1; strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stb === 1'b1) strobes++;
    end
    check("held high strobes", 32'(strobes), 32'd1);
    check("held high instr", 32'(ins), 32'hB7);
    ck = 1'b0;
    tick();

    // Reset mid-RUN, then a rise without reloading.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst load_ready", 32'(rdy), 32'd1);
    check("mid rst running", 32'(run), 32'd0);
    check("mid rst prog_len", 32'(len), 32'd0);
    check("mid rst instruction", 32'(ins), 32'h00);
    pc = 8'h00; ck = 1'b1;
    tick();
    check("idle rise no strobe", 32'(stb), 32'd0);
    tick();
    check("idle rise instr", 32'(ins), 32'h00);
    check("idle rise no strobe 2", 32'(stb), 32'd0);
    ck = 1'b0;

    // Reload a single byte; old contents beyond it stay unreachable.
    vld = 1'b1; dat = 8'h3C; lst = 1'b1;
    tick();
    vld = 1'b0; lst = 1'b0;
    check("reload running", 32'(run), 32'd1);
    check("reload prog_len", 32'(len), 32'd1);
    pc = 8'h01; ck = 1'b1;
    tick();
    check("stale addr fill", 32'(ins), 32'h00);
    check("stale addr strobe", 32'(stb), 32'd1);
    ck = 1'b0;
    tick();
    pc = 8'h00; ck = 1'b1;
    tick();
    check("reload fetch", 32'(ins), 32'h3C);
    ck = 1'b0;
    tick();

    // DEPTH=4: five bytes without load_last; memory full ends the load.
    for (int i = 0; i < 5; i++) begin
      vld4 = 1'b1; dat4 = 8'(8'h11 * (i + 1));
      check($sformatf("d4 ready[%0d]", i), 32'(rdy4), (i < 4) ? 32'd1 : 32'd0);
      tick();
      if (i == 3) begin
        check("d4 run after 4", 32'(run4), 32'd1);
        check("d4 prog_len 4", 32'(len4), 32'd4);
      end
    end
    vld4 = 1'b0;
    check("d4 prog_len sat", 32'(len4), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp4;
      case (i)
        0:       begin pc4 = 8'h00; exp4 = 8'h11; end
        1:       begin pc4 = 8'h03; exp4 = 8'h44; end
        2:       begin pc4 = 8'h04; exp4 = 8'h00; end
        default: begin pc4 = 8'hFF; exp4 = 8'h00; end
      endcase
      ck4 = 1'b1;
      tick();
      check($sformatf("d4 fetch[%0d]", i), 32'(ins4), 32'(exp4));
      check($sformatf("d4 strobe[%0d]", i), 32'(stb4), 32'd1);
      ck4 = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
